// File: rtl/pipelined_control_unit.sv
// pipelined_control_unit
//   Main controller for the 5-stage MIPS datapath. Decodes the ID-stage opcode
//   into EX/M/WB/Jump control bundles and carries them through the ID/EX,
//   EX/MEM and MEM/WB control registers. Also detects load-use hazards and
//   stalls for LOADUSE_STALL cycles. It flushes on a taken branch (resolved
//   in MEM) and on an ID-stage jump.
//
// Handshake: none. This is a lock-step pipeline. Stall holds PC and IF/ID
//   upstream. FlushIFID zeroes the IF/ID instruction register upstream.
//
// Ports:
//   Clk          in   rising-edge clock
//   Rst_n        in   asynchronous active-low reset
//   OpCode       in   IF/ID instruction [31:26]
//   Rs           in   IF/ID instruction [25:21]
//   Rt           in   IF/ID instruction [20:16]
//   BranchTaken  in   branch resolved taken in MEM stage
//   EX           out  ID/EX bundle  {shsb[1:0], ALUOp[3:0], ALUSrc, RegDst[1:0]}
//   M            out  EX/MEM bundle {Branch, MemRead, MemWrite, SpecBranch, BNE}
//   WB           out  MEM/WB bundle {lblh, MemToReg[1:0], RegWrite}
//   Jump         out  ID-stage jump, suppressed while stalling
//   Stall        out  hold PC and IF/ID
//   FlushIFID    out  zero the IF/ID instruction
module pipelined_control_unit #(
    parameter int REG_AW        = 5,
    parameter int LOADUSE_STALL = 1,   // legal range 1..3
    parameter int R0_IGNORE     = 1
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic [5:0]        OpCode,
    input  logic [REG_AW-1:0] Rs,
    input  logic [REG_AW-1:0] Rt,
    input  logic              BranchTaken,
    output logic [8:0]        EX,
    output logic [4:0]        M,
    output logic [3:0]        WB,
    output logic              Jump,
    output logic              Stall,
    output logic              FlushIFID
);

    // Value loaded into the stall counter on a fresh hazard. The hazard cycle
    // itself is the first bubble, so the counter covers the remaining ones.
    localparam logic [1:0] STALL_RELOAD = 2'(LOADUSE_STALL - 1);

    // ---------------- ID-stage decode ----------------
    logic [8:0] dec_ex;
    logic [4:0] dec_m;
    logic [3:0] dec_wb;
    logic       dec_jump;
    logic       uses_rt;

    always_comb begin
        dec_ex   = '0;
        dec_m    = '0;
        dec_wb   = '0;
        dec_jump = 1'b0;
        uses_rt  = 1'b0;
        case (OpCode)
            6'b000000: begin  // R-type
                dec_ex  = 9'b00_0000_0_01;
                dec_wb  = 4'b0_01_1;
                uses_rt = 1'b1;
            end
            6'b000001: begin  // BGEZ / BLTZ
                dec_ex = 9'b00_0010_1_00;
                dec_m  = 5'b10010;
            end
            6'b000010: begin  // J
                dec_jump = 1'b1;
            end
            6'b000011: begin  // JAL: writes the link register
                dec_ex   = 9'b00_0000_0_10;
                dec_wb   = 4'b0_10_1;
                dec_jump = 1'b1;
            end
            6'b000100: begin  // BEQ
                dec_ex  = 9'b00_0001_0_00;
                dec_m   = 5'b10000;
                uses_rt = 1'b1;
            end
            6'b000101: begin  // BNE
                dec_ex  = 9'b00_0001_0_00;
                dec_m   = 5'b10001;
                uses_rt = 1'b1;
            end
            6'b000110: begin  // BLEZ
                dec_ex = 9'b00_0011_0_00;
                dec_m  = 5'b10010;
            end
            6'b000111: begin  // BGTZ
                dec_ex = 9'b00_0100_0_00;
                dec_m  = 5'b10010;
            end
            6'b001000: begin  // ADDI
                dec_ex = 9'b00_0101_1_00;
                dec_wb = 4'b0_01_1;
            end
            6'b001010: begin  // SLTI
                dec_ex = 9'b00_0111_1_00;
                dec_wb = 4'b0_01_1;
            end
            6'b001100: begin  // ANDI
                dec_ex = 9'b00_1000_1_00;
                dec_wb = 4'b0_01_1;
            end
            6'b001101: begin  // ORI
                dec_ex = 9'b00_1001_1_00;
                dec_wb = 4'b0_01_1;
            end
            6'b001110: begin  // XORI
                dec_ex = 9'b00_1010_1_00;
                dec_wb = 4'b0_01_1;
            end
            6'b011100: begin  // MUL
                dec_ex  = 9'b00_1011_0_01;
                dec_wb  = 4'b0_01_1;
                uses_rt = 1'b1;
            end
            6'b100000: begin  // LB
                dec_ex = 9'b00_0101_1_00;
                dec_m  = 5'b01000;
                dec_wb = 4'b0_11_1;
            end
            6'b100001: begin  // LH
                dec_ex = 9'b00_0101_1_00;
                dec_m  = 5'b01000;
                dec_wb = 4'b1_11_1;
            end
            6'b100011: begin  // LW
                dec_ex = 9'b00_0101_1_00;
                dec_m  = 5'b01000;
                dec_wb = 4'b0_00_1;
            end
            6'b101000: begin  // SB
                dec_ex  = 9'b10_0101_1_00;
                dec_m   = 5'b00100;
                uses_rt = 1'b1;
            end
            6'b101001: begin  // SH
                dec_ex  = 9'b01_0101_1_00;
                dec_m   = 5'b00100;
                uses_rt = 1'b1;
            end
            6'b101011: begin  // SW
                dec_ex  = 9'b00_0101_1_00;
                dec_m   = 5'b00100;
                uses_rt = 1'b1;
            end
            default: ;        // illegal opcode: safe all-zero bubble
        endcase
    end

    // ---------------- pipeline control registers ----------------
    logic [8:0]        id_ex_ex;
    logic [4:0]        id_ex_m;
    logic [3:0]        id_ex_wb;
    logic [REG_AW-1:0] id_ex_dst_rt;
    logic [4:0]        ex_mem_m;
    logic [3:0]        ex_mem_wb;
    logic [3:0]        mem_wb_wb;
    logic [1:0]        stall_cnt;

    // ---------------- hazard detection ----------------
    logic load_in_ex;
    logic dst_ok;
    logic hz;

    assign load_in_ex = id_ex_m[3];
    assign dst_ok     = (R0_IGNORE == 0) || (id_ex_dst_rt != '0);
    assign hz         = load_in_ex && dst_ok &&
                        ((id_ex_dst_rt == Rs) || (uses_rt && (id_ex_dst_rt == Rt)));

    // A taken branch squashes the stalled instruction anyway, so it wins.
    assign Stall     = ~BranchTaken & (hz | (stall_cnt != 2'd0));
    assign Jump      = dec_jump & ~Stall;
    assign FlushIFID = BranchTaken | Jump;

    assign EX = id_ex_ex;
    assign M  = ex_mem_m;
    assign WB = mem_wb_wb;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            id_ex_ex     <= '0;
            id_ex_m      <= '0;
            id_ex_wb     <= '0;
            id_ex_dst_rt <= '0;
            ex_mem_m     <= '0;
            ex_mem_wb    <= '0;
            mem_wb_wb    <= '0;
            stall_cnt    <= '0;
        end else begin
            if (BranchTaken) begin
                stall_cnt <= 2'd0;
            end else if (hz && (stall_cnt == 2'd0)) begin
                stall_cnt <= STALL_RELOAD;
            end else if (stall_cnt != 2'd0) begin
                stall_cnt <= stall_cnt - 2'd1;
            end

            // Bubble into EX while stalling or squashing a wrong-path fetch.
            if (BranchTaken || Stall) begin
                id_ex_ex     <= '0;
                id_ex_m      <= '0;
                id_ex_wb     <= '0;
                id_ex_dst_rt <= '0;
            end else begin
                id_ex_ex     <= dec_ex;
                id_ex_m      <= dec_m;
                id_ex_wb     <= dec_wb;
                id_ex_dst_rt <= Rt;
            end

            // The branch itself sits in MEM; everything younger is squashed.
            if (BranchTaken) begin
                ex_mem_m  <= '0;
                ex_mem_wb <= '0;
            end else begin
                ex_mem_m  <= id_ex_m;
                ex_mem_wb <= id_ex_wb;
            end

            mem_wb_wb <= ex_mem_wb;
        end
    end

endmodule

// File: tb/tb_pipelined_control_unit.sv
module tb_pipelined_control_unit;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_ILL  = 6'b111111;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] op_code;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       branch_taken;

    logic [8:0] ex,  ex2;
    logic [4:0] m,   m2;
    logic [3:0] wb,  wb2;
    logic       jump, jump2, stall, stall2, flush, flush2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipelined_control_unit u_dut (
        .Clk(clk), .Rst_n(rst_n), .OpCode(op_code), .Rs(rs), .Rt(rt),
        .BranchTaken(branch_taken), .EX(ex), .M(m), .WB(wb),
        .Jump(jump), .Stall(stall), .FlushIFID(flush)
    );

    pipelined_control_unit #(.LOADUSE_STALL(2)) u_dut2 (
        .Clk(clk), .Rst_n(rst_n), .OpCode(op_code), .Rs(rs), .Rt(rt),
        .BranchTaken(branch_taken), .EX(ex2), .M(m2), .WB(wb2),
        .Jump(jump2), .Stall(stall2), .FlushIFID(flush2)
    );

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] op, input logic [4:0] s, input logic [4:0] t);
        op_code = op;
        rs      = s;
        rt      = t;
        #1;
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        op_code      = OP_ILL;
        rs           = '0;
        rt           = '0;
        branch_taken = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        drive(OP_LW, 5'd0, 5'd0);
        total++; if (ex !== 9'b0)   begin bad++; $display("FAIL reset_ex got=%b exp=%b", ex, 9'b0); end
        total++; if (m !== 5'b0)    begin bad++; $display("FAIL reset_m got=%b exp=%b", m, 5'b0); end
        total++; if (wb !== 4'b0)   begin bad++; $display("FAIL reset_wb got=%b exp=%b", wb, 4'b0); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall); end
        drive(OP_J, 5'd0, 5'd0);
        total++; if (jump !== 1'b1) begin bad++; $display("FAIL reset_jump got=%b exp=1", jump); end
        total++; if (flush !== 1'b1) begin bad++; $display("FAIL reset_flush got=%b exp=1", flush); end
        do_reset();
    endtask

    task automatic test_lw_latency();
        do_reset();
        drive(OP_LW, 5'd0, 5'd9);
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL lat_stall got=%b exp=0", stall); end
        tick();
        total++; if (ex !== 9'b000101100) begin bad++; $display("FAIL lat_ex got=%b exp=%b", ex, 9'b000101100); end
        drive(OP_R, 5'd0, 5'd0);
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL lat_nop_stall got=%b exp=0", stall); end
        tick();
        total++; if (m !== 5'b01000) begin bad++; $display("FAIL lat_m got=%b exp=%b", m, 5'b01000); end
        total++; if (ex !== 9'b000000001) begin bad++; $display("FAIL lat_nop_ex got=%b exp=%b", ex, 9'b000000001); end
        drive(OP_ILL, 5'd0, 5'd0);
        tick();
        total++; if (wb !== 4'b0001) begin bad++; $display("FAIL lat_wb got=%b exp=%b", wb, 4'b0001); end
        total++; if (wb2 !== 4'b0001) begin bad++; $display("FAIL lat_wb2 got=%b exp=%b", wb2, 4'b0001); end
    endtask

    task automatic test_decode();
        logic [5:0] op_t [22];
        logic [8:0] ex_t [22];
        logic [4:0] m_t  [22];
        logic [3:0] wb_t [22];
        logic       j_t  [22];
        op_t = '{6'b000000, 6'b000001, 6'b000010, 6'b000011, 6'b000100, 6'b000101,
                 6'b000110, 6'b000111, 6'b001000, 6'b001010, 6'b001100, 6'b001101,
                 6'b001110, 6'b011100, 6'b100000, 6'b100001, 6'b100011, 6'b101000,
                 6'b101001, 6'b101011, 6'b001001, 6'b111111};
        ex_t = '{9'b000000001, 9'b000010100, 9'b000000000, 9'b000000010, 9'b000001000, 9'b000001000,
                 9'b000011000, 9'b000100000, 9'b000101100, 9'b000111100, 9'b001000100, 9'b001001100,
                 9'b001010100, 9'b001011001, 9'b000101100, 9'b000101100, 9'b000101100, 9'b100101100,
                 9'b010101100, 9'b000101100, 9'b000000000, 9'b000000000};
        m_t  = '{5'b00000, 5'b10010, 5'b00000, 5'b00000, 5'b10000, 5'b10001,
                 5'b10010, 5'b10010, 5'b00000, 5'b00000, 5'b00000, 5'b00000,
                 5'b00000, 5'b00000, 5'b01000, 5'b01000, 5'b01000, 5'b00100,
                 5'b00100, 5'b00100, 5'b00000, 5'b00000};
        wb_t = '{4'b0011, 4'b0000, 4'b0000, 4'b0101, 4'b0000, 4'b0000,
                 4'b0000, 4'b0000, 4'b0011, 4'b0011, 4'b0011, 4'b0011,
                 4'b0011, 4'b0011, 4'b0111, 4'b1111, 4'b0001, 4'b0000,
                 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        j_t  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 22; i++) begin
            do_reset();
            drive(op_t[i], 5'd0, 5'd0);
            total++; if (jump !== j_t[i]) begin bad++; $display("FAIL dec_jump op=%b got=%b exp=%b", op_t[i], jump, j_t[i]); end
            tick();
            total++; if (ex !== ex_t[i]) begin bad++; $display("FAIL dec_ex op=%b got=%b exp=%b", op_t[i], ex, ex_t[i]); end
            drive(OP_ILL, 5'd0, 5'd0);
            tick();
            total++; if (m !== m_t[i]) begin bad++; $display("FAIL dec_m op=%b got=%b exp=%b", op_t[i], m, m_t[i]); end
            tick();
            total++; if (wb !== wb_t[i]) begin bad++; $display("FAIL dec_wb op=%b got=%b exp=%b", op_t[i], wb, wb_t[i]); end
        end
    endtask

    task automatic test_load_use();
        do_reset();
        drive(OP_LW, 5'd1, 5'd5);
        tick();
        drive(OP_R, 5'd5, 5'd2);
        total++; if (stall !== 1'b1)  begin bad++; $display("FAIL lu_stall1 got=%b exp=1", stall); end
        total++; if (stall2 !== 1'b1) begin bad++; $display("FAIL lu2_stall1 got=%b exp=1", stall2); end
        total++; if (flush !== 1'b0)  begin bad++; $display("FAIL lu_flush got=%b exp=0", flush); end
        tick();
        total++; if (ex !== 9'b0)     begin bad++; $display("FAIL lu_bubble_ex got=%b exp=%b", ex, 9'b0); end
        total++; if (m2 !== 5'b01000) begin bad++; $display("FAIL lu2_m got=%b exp=%b", m2, 5'b01000); end
        total++; if (stall !== 1'b0)  begin bad++; $display("FAIL lu_stall2 got=%b exp=0", stall); end
        total++; if (stall2 !== 1'b1) begin bad++; $display("FAIL lu2_stall2 got=%b exp=1", stall2); end
        tick();
        total++; if (ex !== 9'b000000001) begin bad++; $display("FAIL lu_r_ex got=%b exp=%b", ex, 9'b000000001); end
        total++; if (ex2 !== 9'b0)    begin bad++; $display("FAIL lu2_bubble2 got=%b exp=%b", ex2, 9'b0); end
        total++; if (stall2 !== 1'b0) begin bad++; $display("FAIL lu2_stall3 got=%b exp=0", stall2); end
        tick();
        total++; if (ex2 !== 9'b000000001) begin bad++; $display("FAIL lu2_r_ex got=%b exp=%b", ex2, 9'b000000001); end
        // Rt used as a source by a store
        do_reset();
        drive(OP_LW, 5'd0, 5'd6);
        tick();
        drive(OP_SW, 5'd1, 5'd6);
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL lu_sw_stall got=%b exp=1", stall); end
    endtask

    task automatic test_no_stall();
        do_reset();
        drive(OP_LW, 5'd0, 5'd0);
        tick();
        drive(OP_R, 5'd0, 5'd0);
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL r0_stall got=%b exp=0", stall); end
        tick();
        drive(OP_LW, 5'd0, 5'd7);
        tick();
        drive(OP_ADDI, 5'd3, 5'd7);
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL addi_rt_stall got=%b exp=0", stall); end
        tick();
        total++; if (ex !== 9'b000101100) begin bad++; $display("FAIL addi_ex got=%b exp=%b", ex, 9'b000101100); end
    endtask

    task automatic test_branch_flush();
        // taken branch during a load-use stall
        do_reset();
        drive(OP_LW, 5'd0, 5'd5);
        tick();
        branch_taken = 1'b1;
        drive(OP_R, 5'd5, 5'd2);
        total++; if (stall !== 1'b0)  begin bad++; $display("FAIL br_stall got=%b exp=0", stall); end
        total++; if (stall2 !== 1'b0) begin bad++; $display("FAIL br_stall2 got=%b exp=0", stall2); end
        total++; if (flush !== 1'b1)  begin bad++; $display("FAIL br_flush got=%b exp=1", flush); end
        total++; if (flush2 !== 1'b1) begin bad++; $display("FAIL br_flush2 got=%b exp=1", flush2); end
        tick();
        total++; if (ex !== 9'b0)  begin bad++; $display("FAIL br_ex got=%b exp=%b", ex, 9'b0); end
        total++; if (m !== 5'b0)   begin bad++; $display("FAIL br_m got=%b exp=%b", m, 5'b0); end
        branch_taken = 1'b0;
        #1;
        total++; if (stall2 !== 1'b0) begin bad++; $display("FAIL br_cnt_clear got=%b exp=0", stall2); end
        // MEM/WB keeps the instruction that was already in MEM
        do_reset();
        drive(OP_LW, 5'd0, 5'd9);
        tick();
        drive(OP_LW, 5'd0, 5'd10);
        tick();
        branch_taken = 1'b1;
        drive(OP_ILL, 5'd0, 5'd0);
        tick();
        branch_taken = 1'b0;
        total++; if (ex !== 9'b0)    begin bad++; $display("FAIL brw_ex got=%b exp=%b", ex, 9'b0); end
        total++; if (m !== 5'b0)     begin bad++; $display("FAIL brw_m got=%b exp=%b", m, 5'b0); end
        total++; if (wb !== 4'b0001) begin bad++; $display("FAIL brw_wb got=%b exp=%b", wb, 4'b0001); end
    endtask

    task automatic test_jump();
        do_reset();
        drive(OP_JAL, 5'd0, 5'd0);
        total++; if (jump !== 1'b1)  begin bad++; $display("FAIL jal_jump got=%b exp=1", jump); end
        total++; if (flush !== 1'b1) begin bad++; $display("FAIL jal_flush got=%b exp=1", flush); end
        tick();
        total++; if (ex !== 9'b000000010) begin bad++; $display("FAIL jal_ex got=%b exp=%b", ex, 9'b000000010); end
        drive(OP_ILL, 5'd0, 5'd0);
        tick();
        tick();
        total++; if (wb !== 4'b0101) begin bad++; $display("FAIL jal_wb got=%b exp=%b", wb, 4'b0101); end
        // J while stalled must not redirect
        do_reset();
        drive(OP_LW, 5'd0, 5'd5);
        tick();
        drive(OP_J, 5'd5, 5'd0);
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL jst_stall got=%b exp=1", stall); end
        total++; if (jump !== 1'b0)  begin bad++; $display("FAIL jst_jump got=%b exp=0", jump); end
        total++; if (jump2 !== 1'b0) begin bad++; $display("FAIL jst_jump2 got=%b exp=0", jump2); end
        total++; if (flush !== 1'b0) begin bad++; $display("FAIL jst_flush got=%b exp=0", flush); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        drive(OP_LW, 5'd0, 5'd9);
        tick();
        drive(OP_LW, 5'd0, 5'd10);
        tick();
        drive(OP_LW, 5'd0, 5'd11);
        tick();
        drive(OP_R, 5'd11, 5'd0);
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL mr_pre_stall got=%b exp=1", stall); end
        total++; if (wb !== 4'b0001) begin bad++; $display("FAIL mr_pre_wb got=%b exp=%b", wb, 4'b0001); end
        rst_n = 1'b0;
        #1;
        total++; if (ex !== 9'b0)    begin bad++; $display("FAIL mr_ex got=%b exp=%b", ex, 9'b0); end
        total++; if (m !== 5'b0)     begin bad++; $display("FAIL mr_m got=%b exp=%b", m, 5'b0); end
        total++; if (wb !== 4'b0)    begin bad++; $display("FAIL mr_wb got=%b exp=%b", wb, 4'b0); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL mr_stall got=%b exp=0", stall); end
        tick();
        rst_n = 1'b1;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst_n        = 1'b0;
        op_code      = OP_ILL;
        rs           = '0;
        rt           = '0;
        branch_taken = 1'b0;
        test_reset();
        test_lw_latency();
        test_decode();
        test_load_use();
        test_no_stall();
        test_branch_flush();
        test_jump();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipelined_control_unit.md
Name: pipelined_control_unit

Overview:
- Next-generation main controller for the 5-stage MIPS datapath.
- Decodes OpCode in ID into EX/M/WB/Jump control bundles and carries them through the ID/EX, EX/MEM and MEM/WB control registers.
- Adds what the combinational decoder lacked: load-use hazard stall with parametrised stall depth, and branch/jump flush.
- Drives a safe all-zero bubble for illegal opcodes.

Parameters:
REG_AW, 5, register-specifier width
LOADUSE_STALL, 1, bubbles inserted per load-use hazard (1 = forwarding present, 2 = no MEM->EX forwarding); legal values 1..3
R0_IGNORE, 1, when 1, a hazard on register 0 never stalls

Ports:
Clk  in  1  rising-edge clock
Rst_n  in  1  asynchronous active-low reset
OpCode  in  6  IF/ID instruction [31:26]
Rs  in  REG_AW  IF/ID instruction [25:21]
Rt  in  REG_AW  IF/ID instruction [20:16]
BranchTaken  in  1  branch resolved taken in MEM stage
EX  out  9  ID/EX bundle: [8:7] shsb, [6:3] ALUOp, [2] ALUSrc, [1:0] RegDst
M  out  5  EX/MEM bundle: [4] Branch, [3] MemRead, [2] MemWrite, [1] SpecBranch, [0] BNE
WB  out  4  MEM/WB bundle: [3] lblh, [2:1] MemToReg, [0] RegWrite
Jump  out  1  combinational: ID-stage jump, 0 while Stall
Stall  out  1  combinational: hold PC and IF/ID
FlushIFID  out  1  combinational: zero the IF/ID instruction

Behaviour:
- Decode table, combinational in ID, written as EX / M / WB / Jump; all don't-cares drive 0:
  000000 R: 0_0000_0_01 / 00000 / 0_01_1 / 0
  000001 BGEZ/BLTZ: 0_0010_1_00 / 10010 / 0 / 0
  000010 J: 0 / 0 / 0 / 1
  000011 JAL: 0_0000_0_10 / 0 / 0_10_1 / 1
  000100 BEQ: ALUOp 0001, M 10000
  000101 BNE: ALUOp 0001, M 10001
  000110 BLEZ: ALUOp 0011, M 10010
  000111 BGTZ: ALUOp 0100, M 10010
  ALU-immediate, all ALUSrc 1, RegDst 00, WB 0_01_1; ALUOp: 001000 ADDI 0101, 001010 SLTI 0111, 001100 ANDI 1000, 001101 ORI 1001, 001110 XORI 1010
  011100 MUL: 0_1011_0_01 / 0 / 0_01_1
  100000 LB: 0_0101_1_00 / 01000 / 0_11_1
  100001 LH: 0_0101_1_00 / 01000 / 1_11_1
  100011 LW: 0_0101_1_00 / 01000 / 0_00_1
  101000 SB: 10_0101_1_00 / 00100 / 0
  101001 SH: 01_0101_1_00 / 00100 / 0
  101011 SW: 00_0101_1_00 / 00100 / 0
  Any other opcode: all zero.
- Rt-as-source (UsesRt) is 1 for: R, BEQ, BNE, MUL, SB, SH, SW.
- Pipeline: ID/EX holds EX, M, WB, and a DstRt copy of Rt. EX/MEM holds M and WB. MEM/WB holds WB. Latency OpCode->EX 1 cycle, ->M 2 cycles, ->WB 3 cycles.
- Hazard detection: Hz = ID/EX.MemRead & ((DstRt==Rs) | (UsesRt & DstRt==Rt)). If R0_IGNORE, also require DstRt != 0.
- Stall counter StallCnt, 2 bits:
  - Stall = Hz | (StallCnt != 0).
  - On Hz with StallCnt==0, StallCnt <= LOADUSE_STALL-1.
  - Otherwise, if StallCnt != 0, it decrements.
  - While Stall, ID/EX loads a bubble (all zero, DstRt 0). EX/MEM and MEM/WB advance normally.
- Flush on BranchTaken:
  - Highest priority; overrides Stall, forcing Stall=0.
  - FlushIFID=1 and StallCnt <= 0.
  - ID/EX and EX/MEM load bubbles next edge. MEM/WB still takes the old EX/MEM WB.
- Flush on jump: when Jump=1, FlushIFID=1 in the same cycle, and the jump's own bundle still enters ID/EX (JAL must write back).
- Reset: Rst_n low asynchronously clears all pipeline registers and StallCnt, so EX, M, WB = 0 and Stall = 0. Combinational outputs then follow OpCode; a mid-pipeline reset drops all in-flight control.

Test Plan:
- Reset, then LW at cycle 0 followed by NOP: EX=9'b0_0101_1_00 at cycle 1, M=5'b01000 at cycle 2, WB=4'b0001 at cycle 3.
- LW Rt=5, then R-type Rs=5: Stall=1 for 1 cycle, EX=0 the next cycle, R-type bundle appears one cycle later. With LOADUSE_STALL=2, Stall is high for 2 cycles.
- LW Rt=0, then R-type Rs=0, R0_IGNORE=1: no Stall. LW Rt=7, then ADDI Rt=7 (Rt not a source): no Stall.
- BranchTaken=1 during a load-use stall: Stall=0 and FlushIFID=1 that cycle; EX=0 and M=0 next cycle; StallCnt cleared.
- JAL in ID: Jump=1, FlushIFID=1 same cycle; WB=4'b0101 three cycles later. J during Stall: Jump=0.
- Opcode 111111 gives all-zero bundles downstream. Rst_n asserted mid-stream between edges: EX, M, WB, Stall = 0 immediately.
